// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator CPU.
// Optional single-step mode: define SINGLE_STEP_EN to add the step/waiting handshake.
module instruction_sequencer #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic       zero,
`ifdef SINGLE_STEP_EN
   input  logic       step,
   output logic       waiting,
`endif
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       addr_sel,
   output logic       mem_read,
   output logic       mem_write,
   output logic       load_acc,
   output logic [1:0] acc_src,
   output logic [2:0] alu_op,
   output logic       halted
);

   localparam int unsigned WAIT_W = 3;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT - 1);

   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_MEMRD, S_HALT, S_STEPWAIT
   } state_t;

   state_t            r_state, w_state_nxt, w_done_state;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;

   logic       r_load_ir, r_inc_pc, r_load_pc, r_addr_sel;
   logic       r_mem_read, r_mem_write, r_load_acc, r_halted;
   logic [1:0] r_acc_src;
   logic [2:0] r_alu_op;

   logic       w_load_ir, w_inc_pc, w_load_pc, w_addr_sel;
   logic       w_mem_read, w_mem_write, w_load_acc, w_halted;
   logic [1:0] w_acc_src;
   logic [2:0] w_alu_op;

`ifdef SINGLE_STEP_EN
   logic r_step_d, r_waiting, w_waiting, w_step_rise;
   assign w_step_rise  = step & ~r_step_d;
   assign w_done_state = S_STEPWAIT;
`else
   assign w_done_state = S_FETCH;
`endif

   // Next state and wait counter; the counter reloads whenever a wait state is entered.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      case (r_state)
         S_RST:    w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (r_wait == '0) w_state_nxt = S_LOAD;
            else              w_wait_nxt  = r_wait - WAIT_W'(1);
         end
         S_LOAD:   w_state_nxt = S_DECODE;
         S_DECODE: w_state_nxt = S_EXEC;
         S_EXEC: begin
            case (opcode)
               OP_LDA:  w_state_nxt = S_MEMRD;
               OP_HLT:  w_state_nxt = S_HALT;
               default: w_state_nxt = w_done_state;
            endcase
         end
         S_MEMRD: begin
            if (r_wait == '0) w_state_nxt = w_done_state;
            else              w_wait_nxt  = r_wait - WAIT_W'(1);
         end
         S_HALT:   w_state_nxt = S_HALT;
`ifdef SINGLE_STEP_EN
         S_STEPWAIT: if (w_step_rise) w_state_nxt = S_FETCH;
`endif
         default:  w_state_nxt = S_RST;
      endcase
      if ((w_state_nxt != r_state) &&
          ((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEMRD)))
         w_wait_nxt = WAIT_INIT;
   end

   // Outputs decoded from the upcoming state so they are registered yet aligned with it.
   always_comb begin
      w_load_ir   = 1'b0;
      w_inc_pc    = 1'b0;
      w_load_pc   = 1'b0;
      w_addr_sel  = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_load_acc  = 1'b0;
      w_acc_src   = 2'd0;
      w_alu_op    = 3'd0;
      w_halted    = 1'b0;
`ifdef SINGLE_STEP_EN
      w_waiting   = 1'b0;
`endif
      case (w_state_nxt)
         S_FETCH: w_mem_read = 1'b1;
         S_LOAD: begin
            w_load_ir = 1'b1;
            w_inc_pc  = 1'b1;
         end
         S_EXEC: begin
            case (opcode)
               OP_LDI: begin
                  w_load_acc = 1'b1;
                  w_acc_src  = 2'd1;
               end
               OP_LDA: begin
                  w_mem_read = 1'b1;
                  w_addr_sel = 1'b1;
               end
               OP_STA: begin
                  w_mem_write = 1'b1;
                  w_addr_sel  = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  w_load_acc = 1'b1;
                  w_alu_op   = {1'b0, opcode[1:0]};
               end
               OP_JMP:  w_load_pc = 1'b1;
               OP_JZ:   w_load_pc = zero;
               default: w_load_pc = 1'b0;
            endcase
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_addr_sel = 1'b1;
            if (w_wait_nxt == '0) begin
               w_load_acc = 1'b1;
               w_acc_src  = 2'd2;
            end
         end
         S_HALT: w_halted = 1'b1;
`ifdef SINGLE_STEP_EN
         S_STEPWAIT: w_waiting = 1'b1;
`endif
         default: w_halted = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_RST;
         r_wait      <= '0;
         r_load_ir   <= 1'b0;
         r_inc_pc    <= 1'b0;
         r_load_pc   <= 1'b0;
         r_addr_sel  <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_load_acc  <= 1'b0;
         r_acc_src   <= 2'd0;
         r_alu_op    <= 3'd0;
         r_halted    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait      <= w_wait_nxt;
         r_load_ir   <= w_load_ir;
         r_inc_pc    <= w_inc_pc;
         r_load_pc   <= w_load_pc;
         r_addr_sel  <= w_addr_sel;
         r_mem_read  <= w_mem_read;
         r_mem_write <= w_mem_write;
         r_load_acc  <= w_load_acc;
         r_acc_src   <= w_acc_src;
         r_alu_op    <= w_alu_op;
         r_halted    <= w_halted;
      end
   end

`ifdef SINGLE_STEP_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_step_d  <= 1'b0;
         r_waiting <= 1'b0;
      end else begin
         r_step_d  <= step;
         r_waiting <= w_waiting;
      end
   end
   assign waiting = r_waiting;
`endif

   assign load_ir   = r_load_ir;
   assign inc_pc    = r_inc_pc;
   assign load_pc   = r_load_pc;
   assign addr_sel  = r_addr_sel;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign load_acc  = r_load_acc;
   assign acc_src   = r_acc_src;
   assign alu_op    = r_alu_op;
   assign halted    = r_halted;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: one MEM_WAIT=1 and one MEM_WAIT=3 instance.
module tb_instruction_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] opcode1 = 4'h0, opcode3 = 4'h0;
   logic       zero1 = 1'b0, zero3 = 1'b0;
   logic       step1 = 1'b0, step3 = 1'b0;
   logic       waiting1, waiting3;

   logic       load_ir1, inc_pc1, load_pc1, addr_sel1, mem_read1, mem_write1, load_acc1, halted1;
   logic [1:0] acc_src1;
   logic [2:0] alu_op1;
   logic       load_ir3, inc_pc3, load_pc3, addr_sel3, mem_read3, mem_write3, load_acc3, halted3;
   logic [1:0] acc_src3;
   logic [2:0] alu_op3;

   int checks = 0;
   int errors = 0;

   // Packed view: load_ir inc_pc load_pc addr_sel mem_read mem_write load_acc acc_src[2] alu_op[3] halted
   wire logic [12:0] obs1 = {load_ir1, inc_pc1, load_pc1, addr_sel1, mem_read1, mem_write1,
                             load_acc1, acc_src1, alu_op1, halted1};
   wire logic [12:0] obs3 = {load_ir3, inc_pc3, load_pc3, addr_sel3, mem_read3, mem_write3,
                             load_acc3, acc_src3, alu_op3, halted3};

   localparam logic [12:0] O_IDLE  = 13'h0000;
   localparam logic [12:0] O_FETCH = 13'h0100;
   localparam logic [12:0] O_LOAD  = 13'h1800;
   localparam logic [12:0] O_LDI   = 13'h0050;
   localparam logic [12:0] O_ADD   = 13'h0040;
   localparam logic [12:0] O_SUB   = 13'h0042;
   localparam logic [12:0] O_AND   = 13'h0044;
   localparam logic [12:0] O_OR    = 13'h0046;
   localparam logic [12:0] O_RDMEM = 13'h0300;
   localparam logic [12:0] O_RDACC = 13'h0360;
   localparam logic [12:0] O_STA   = 13'h0280;
   localparam logic [12:0] O_JMP   = 13'h0400;
   localparam logic [12:0] O_HALT  = 13'h0001;

   instruction_sequencer #(.MEM_WAIT(1)) u_dut1 (
      .clock(clock), .reset(reset), .opcode(opcode1), .zero(zero1),
`ifdef SINGLE_STEP_EN
      .step(step1), .waiting(waiting1),
`endif
      .load_ir(load_ir1), .inc_pc(inc_pc1), .load_pc(load_pc1), .addr_sel(addr_sel1),
      .mem_read(mem_read1), .mem_write(mem_write1), .load_acc(load_acc1),
      .acc_src(acc_src1), .alu_op(alu_op1), .halted(halted1)
   );

   instruction_sequencer #(.MEM_WAIT(3)) u_dut3 (
      .clock(clock), .reset(reset), .opcode(opcode3), .zero(zero3),
`ifdef SINGLE_STEP_EN
      .step(step3), .waiting(waiting3),
`endif
      .load_ir(load_ir3), .inc_pc(inc_pc3), .load_pc(load_pc3), .addr_sel(addr_sel3),
      .mem_read(mem_read3), .mem_write(mem_write3), .load_acc(load_acc3),
      .acc_src(acc_src3), .alu_op(alu_op3), .halted(halted3)
   );

`ifndef SINGLE_STEP_EN
   assign waiting1 = 1'b0;
   assign waiting3 = 1'b0;
`endif

   always #5 clock = ~clock;

   // Leaves the bench at the negedge of cycle 0 (the RST cycle).
   task automatic start_reset();
      @(posedge clock); #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      @(posedge clock); #1 reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (obs1 !== O_IDLE || obs3 !== O_IDLE) begin
            errors++; $display("FAIL reset_hold got %h/%h want %h", obs1, obs3, O_IDLE);
         end
      end
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if (obs1 !== O_IDLE || obs3 !== O_IDLE) begin
         errors++; $display("FAIL reset_rst got %h/%h want %h", obs1, obs3, O_IDLE);
      end
      @(negedge clock);
      checks++;
      if (obs1 !== O_FETCH || obs3 !== O_FETCH) begin
         errors++; $display("FAIL reset_fetch got %h/%h want %h", obs1, obs3, O_FETCH);
      end
   endtask

   task automatic test_ldi_add();
      logic [12:0] exp [8] = '{O_FETCH, O_LOAD, O_IDLE, O_LDI, O_FETCH, O_LOAD, O_IDLE, O_ADD};
      opcode1 = 4'h1;
      start_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         checks++;
         if (obs1 !== exp[c-1]) begin
            errors++; $display("FAIL ldi_add cycle %0d got %h want %h", c, obs1, exp[c-1]);
         end
         if (c == 6) opcode1 = 4'h4;
      end
   endtask

   task automatic test_opcodes();
      logic [3:0]  ops  [9] = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hE};
      logic [12:0] exps [9] = '{O_IDLE, O_STA, O_SUB, O_AND, O_OR, O_JMP, O_IDLE, O_IDLE, O_IDLE};
      logic [12:0] seq  [4];
      zero1 = 1'b0;
      opcode1 = 4'h0;
      start_reset();
      for (int i = 0; i < 9; i++) begin
         seq = '{O_FETCH, O_LOAD, O_IDLE, exps[i]};
         for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checks++;
            if (obs1 !== seq[c]) begin
               errors++;
               $display("FAIL opcode_%h phase %0d got %h want %h", ops[i], c, obs1, seq[c]);
            end
            if (c == 0) opcode1 = ops[i];
         end
      end
   endtask

   task automatic test_jz();
      logic [12:0] seq [5];
      for (int z = 0; z < 2; z++) begin
         zero1 = 1'(z);
         opcode1 = 4'h9;
         seq = '{O_FETCH, O_LOAD, O_IDLE, (z == 1) ? O_JMP : O_IDLE, O_FETCH};
         start_reset();
         for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (obs1 !== seq[c]) begin
               errors++; $display("FAIL jz_zero%0d cycle %0d got %h want %h", z, c + 1, obs1, seq[c]);
            end
         end
      end
   endtask

   task automatic test_lda();
      logic [12:0] exp1 [10] = '{O_FETCH, O_LOAD, O_IDLE, O_RDMEM, O_RDACC,
                                 O_FETCH, O_LOAD, O_IDLE, O_RDMEM, O_RDACC};
      logic [12:0] exp3 [10] = '{O_FETCH, O_FETCH, O_FETCH, O_LOAD, O_IDLE,
                                 O_RDMEM, O_RDMEM, O_RDMEM, O_RDACC, O_FETCH};
      opcode1 = 4'h2;
      opcode3 = 4'h2;
      start_reset();
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         checks++;
         if (obs1 !== exp1[c-1]) begin
            errors++; $display("FAIL lda_wait1 cycle %0d got %h want %h", c, obs1, exp1[c-1]);
         end
         checks++;
         if (obs3 !== exp3[c-1]) begin
            errors++; $display("FAIL lda_wait3 cycle %0d got %h want %h", c, obs3, exp3[c-1]);
         end
      end
   endtask

   task automatic test_halt();
      logic [12:0] seq [4] = '{O_FETCH, O_LOAD, O_IDLE, O_IDLE};
      opcode1 = 4'hF;
      start_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if (obs1 !== seq[c]) begin
            errors++; $display("FAIL hlt_entry cycle %0d got %h want %h", c + 1, obs1, seq[c]);
         end
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         checks++;
         if (obs1 !== O_HALT) begin
            errors++; $display("FAIL hlt_hold cycle %0d got %h want %h", c, obs1, O_HALT);
         end
      end
      @(posedge clock); #2 reset = 1'b1;
      #1;
      checks++;
      if (obs1 !== O_IDLE) begin
         errors++; $display("FAIL hlt_async_reset got %h want %h", obs1, O_IDLE);
      end
      @(posedge clock); #1 reset = 1'b0;
   endtask

   task automatic test_reset_midwait();
      logic [12:0] exp3 [4] = '{O_FETCH, O_FETCH, O_FETCH, O_LOAD};
      opcode3 = 4'h0;
      start_reset();
      repeat (2) @(negedge clock);
      checks++;
      if (obs3 !== O_FETCH) begin
         errors++; $display("FAIL midwait_pre got %h want %h", obs3, O_FETCH);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (obs3 !== O_IDLE || obs1 !== O_IDLE) begin
         errors++; $display("FAIL midwait_async got %h/%h want %h", obs1, obs3, O_IDLE);
      end
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      checks++;
      if (obs3 !== O_IDLE) begin
         errors++; $display("FAIL midwait_rst got %h want %h", obs3, O_IDLE);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if (obs3 !== exp3[c]) begin
            errors++; $display("FAIL midwait_refetch cycle %0d got %h want %h", c + 1, obs3, exp3[c]);
         end
      end
   endtask

   task automatic test_step();
      logic [12:0] seq [4] = '{O_FETCH, O_LOAD, O_IDLE, O_IDLE};
      opcode1 = 4'h0;
      step1 = 1'b0;
      start_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if (obs1 !== seq[c]) begin
            errors++; $display("FAIL step_first cycle %0d got %h want %h", c + 1, obs1, seq[c]);
         end
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         checks++;
         if (waiting1 !== 1'b1 || obs1 !== O_IDLE) begin
            errors++; $display("FAIL step_wait cycle %0d got %b/%h want 1/%h", c, waiting1, obs1, O_IDLE);
         end
      end
      step1 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         step1 = 1'b0;
         checks++;
         if (waiting1 !== 1'b0 || obs1 !== seq[c]) begin
            errors++; $display("FAIL step_run cycle %0d got %b/%h want 0/%h", c, waiting1, obs1, seq[c]);
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checks++;
         if (waiting1 !== 1'b1 || obs1 !== O_IDLE) begin
            errors++; $display("FAIL step_rewait cycle %0d got %b/%h want 1/%h", c, waiting1, obs1, O_IDLE);
         end
      end
   endtask

   initial begin
      test_reset();
`ifdef SINGLE_STEP_EN
      test_step();
`else
      test_ldi_add();
      test_opcodes();
      test_jz();
      test_lda();
`endif
      test_halt();
      test_reset_midwait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
